// File: rtl/mult_arbiter.sv
// Four-requester round-robin arbiter sharing one pipelined signed 35x35 multiplier;
// each grant returns a*b+c tagged with the requester index, in grant order.

module multiplier35x35 #(
    parameter int LATENCY = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [34:0] a_in,
    input  logic [34:0] b_in,
    output logic [69:0] p_out
);
    logic signed [69:0] a_ext;
    logic signed [69:0] b_ext;
    logic [69:0]        pipe_q [LATENCY];
    logic [69:0]        pipe_d [LATENCY];

    // Low 70 bits of the sign-extended product equal the exact 35x35 signed product.
    always_comb begin
        a_ext = {{35{a_in[34]}}, a_in};
        b_ext = {{35{b_in[34]}}, b_in};
        pipe_d[0] = a_ext * b_ext;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign p_out = pipe_q[LATENCY-1];
endmodule

module mult_arbiter #(
    parameter int MULT_LATENCY = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         enable_in,
    input  logic [3:0]   req_in,
    input  logic [139:0] a_in,
    input  logic [139:0] b_in,
    input  logic [279:0] c_in,
    output logic [3:0]   grant_out,
    output logic [69:0]  p_out,
    output logic         p_valid_out,
    output logic [1:0]   p_id_out,
    output logic         busy_out
);
    // One stage for the operand register plus one per multiplier stage.
    localparam int DL = MULT_LATENCY + 1;

    logic [1:0]  ptr_q, ptr_d;
    logic [34:0] opa_q, opa_d;
    logic [34:0] opb_q, opb_d;
    logic [DL-1:0] vld_q, vld_d;
    logic [69:0] cdl_q [DL];
    logic [69:0] cdl_d [DL];
    logic [1:0]  iddl_q [DL];
    logic [1:0]  iddl_d [DL];
    logic [69:0] p_q, p_d;
    logic [1:0]  p_id_q, p_id_d;
    logic        p_valid_q, p_valid_d;

    logic [69:0] prod;
    logic        gnt_vld;
    logic [1:0]  gnt_id;
    logic [1:0]  scan_id;

    multiplier35x35 #(.LATENCY(MULT_LATENCY)) u_mult (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .a_in   (opa_q),
        .b_in   (opb_q),
        .p_out  (prod)
    );

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 2'd0;
        scan_id = 2'd0;
        if (enable_in && !rst_in) begin
            for (int off = 0; off < 4; off++) begin
                scan_id = ptr_q + 2'(off);
                if (!gnt_vld && req_in[scan_id]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = scan_id;
                end
            end
        end
    end

    assign grant_out = gnt_vld ? (4'b0001 << gnt_id) : 4'b0000;

    always_comb begin
        ptr_d = gnt_vld ? (gnt_id + 2'd1) : ptr_q;
        opa_d = opa_q;
        opb_d = opb_q;
        if (gnt_vld) begin
            opa_d = a_in[35*gnt_id +: 35];
            opb_d = b_in[35*gnt_id +: 35];
        end

        vld_d     = {vld_q[DL-2:0], gnt_vld};
        cdl_d[0]  = c_in[70*gnt_id +: 70];
        iddl_d[0] = gnt_id;
        for (int i = 1; i < DL; i++) begin
            cdl_d[i]  = cdl_q[i-1];
            iddl_d[i] = iddl_q[i-1];
        end

        // Sum wraps modulo 2^70; outputs hold between valid pulses.
        p_valid_d = vld_q[DL-1];
        p_d       = p_q;
        p_id_d    = p_id_q;
        if (vld_q[DL-1]) begin
            p_d    = prod + cdl_q[DL-1];
            p_id_d = iddl_q[DL-1];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            vld_q     <= '0;
            p_q       <= '0;
            p_id_q    <= '0;
            p_valid_q <= 1'b0;
            for (int i = 0; i < DL; i++) begin
                cdl_q[i]  <= '0;
                iddl_q[i] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            vld_q     <= vld_d;
            p_q       <= p_d;
            p_id_q    <= p_id_d;
            p_valid_q <= p_valid_d;
            cdl_q     <= cdl_d;
            iddl_q    <= iddl_d;
        end
    end

    assign p_out       = p_q;
    assign p_id_out    = p_id_q;
    assign p_valid_out = p_valid_q;
    assign busy_out    = (|vld_q) | p_valid_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: fixed vectors, directed corner sequences and random traffic
// checked against a queue-based model of grant order and result timing.

module tb_mult_arbiter;
    localparam int LAT = 4;
    localparam int RESULT_DELAY = LAT + 2;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         enable_in;
    logic [3:0]   req_in;
    logic [139:0] a_in;
    logic [139:0] b_in;
    logic [279:0] c_in;
    logic [3:0]   grant_out;
    logic [69:0]  p_out;
    logic         p_valid_out;
    logic [1:0]   p_id_out;
    logic         busy_out;

    mult_arbiter #(.MULT_LATENCY(LAT)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .enable_in   (enable_in),
        .req_in      (req_in),
        .a_in        (a_in),
        .b_in        (b_in),
        .c_in        (c_in),
        .grant_out   (grant_out),
        .p_out       (p_out),
        .p_valid_out (p_valid_out),
        .p_id_out    (p_id_out),
        .busy_out    (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          due;
        logic [69:0] p;
        logic [1:0]  id;
    } pend_t;

    typedef struct {
        logic [1:0]  who;
        logic [34:0] a;
        logic [34:0] b;
        logic [69:0] c;
        logic [69:0] exp_p;
    } vec_t;

    pend_t       pend_q[$];
    int          m_ptr;
    logic [69:0] last_p;
    logic [1:0]  last_id;
    int          cyc;
    int          n_checks;
    int          n_errors;

    logic [3:0]  smp_grant;
    logic        smp_valid;
    logic [69:0] smp_p;
    logic [1:0]  smp_id;

    vec_t tbl[6];

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [69:0] model_mac(input logic [34:0] a, input logic [34:0] b,
                                              input logic [69:0] c);
        logic signed [139:0] ax, bx, cx, full;
        ax   = {{105{a[34]}}, a};
        bx   = {{105{b[34]}}, b};
        cx   = {{70{c[69]}}, c};
        full = ax * bx + cx;
        return full[69:0];
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < 4; i++) begin
            a_in[35*i +: 35] = 35'({$urandom(), $urandom()});
            b_in[35*i +: 35] = 35'({$urandom(), $urandom()});
            c_in[70*i +: 70] = 70'({$urandom(), $urandom(), $urandom()});
        end
    endtask

    // Entered just after a rising edge; applies inputs, checks this cycle, advances one cycle.
    task automatic step(input logic [3:0] req, input logic en);
        int          g;
        logic        exp_valid;
        logic [3:0]  exp_grant;
        pend_t       e;
        req_in    = req;
        enable_in = en;
        #2;
        g = -1;
        if (en) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && req[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
        end
        exp_grant = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        smp_grant = grant_out;
        smp_valid = p_valid_out;
        smp_p     = p_out;
        smp_id    = p_id_out;
        check("grant", grant_out, exp_grant);

        exp_valid = (pend_q.size() > 0) && (pend_q[0].due == cyc);
        if (exp_valid) begin
            e       = pend_q.pop_front();
            last_p  = e.p;
            last_id = e.id;
        end
        check("p_valid", p_valid_out, exp_valid);
        check("p_out", p_out, last_p);
        check("p_id", p_id_out, last_id);
        check("busy", busy_out, exp_valid || (pend_q.size() > 0));

        if (g >= 0) begin
            e.due = cyc + RESULT_DELAY;
            e.p   = model_mac(a_in[35*g +: 35], b_in[35*g +: 35], c_in[70*g +: 70]);
            e.id  = 2'(g);
            pend_q.push_back(e);
            m_ptr = (g + 1) % 4;
        end
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_in    = 1'b1;
        req_in    = 4'hF;
        enable_in = 1'b1;
        #1;
        check("rst_grant", grant_out, 4'b0000);
        check("rst_busy", busy_out, 1'b0);
        check("rst_valid", p_valid_out, 1'b0);
        check("rst_p", p_out, 70'd0);
        check("rst_id", p_id_out, 2'd0);
        pend_q.delete();
        m_ptr   = 0;
        last_p  = '0;
        last_id = '0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        a_in     = '0;
        b_in     = '0;
        c_in     = '0;
        req_in   = '0;
        enable_in = 1'b0;
        rst_in   = 1'b1;

        tbl[0] = '{who: 2'd0, a: 35'd3, b: -35'sd5, c: 70'd100, exp_p: 70'd85};
        tbl[1] = '{who: 2'd1, a: -35'sd7, b: 35'd6, c: 70'd0, exp_p: -70'sd42};
        tbl[2] = '{who: 2'd2, a: 35'd0, b: 35'd123, c: -70'sd1, exp_p: -70'sd1};
        tbl[3] = '{who: 2'd3, a: 35'h400000000, b: 35'h400000000,
                   c: {1'b0, {69{1'b1}}}, exp_p: {2'b10, {68{1'b1}}}};
        tbl[4] = '{who: 2'd1, a: 35'd100000, b: 35'd100000, c: -70'sd5, exp_p: 70'd9999999995};
        tbl[5] = '{who: 2'd0, a: 35'h7FFFFFFFF, b: 35'h7FFFFFFFF, c: 70'd0, exp_p: 70'd1};

        do_reset();

        // Fixed single-operation vectors: grant now, result exactly six cycles later.
        for (int t = 0; t < 6; t++) begin
            rand_ops();
            a_in[35*tbl[t].who +: 35] = tbl[t].a;
            b_in[35*tbl[t].who +: 35] = tbl[t].b;
            c_in[70*tbl[t].who +: 70] = tbl[t].c;
            step(4'b0001 << tbl[t].who, 1'b1);
            check("vec_grant", smp_grant, 4'b0001 << tbl[t].who);
            for (int j = 1; j <= RESULT_DELAY; j++) begin
                step(4'b0000, 1'b1);
                if (j == RESULT_DELAY) begin
                    check("vec_valid", smp_valid, 1'b1);
                    check("vec_p", smp_p, tbl[t].exp_p);
                    check("vec_id", smp_id, tbl[t].who);
                end
            end
        end

        // Fairness from reset: 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step(4'hF, 1'b1);
            check("fair_grant", smp_grant, 4'b0001 << (i % 4));
        end
        drain(8);

        // Skip: move pointer to 1, then requesters 0 and 3 alternate starting with 3.
        rand_ops();
        step(4'b0001, 1'b1);
        step(4'b1001, 1'b1);
        check("skip_g1", smp_grant, 4'b1000);
        step(4'b1001, 1'b1);
        check("skip_g2", smp_grant, 4'b0001);
        step(4'b1001, 1'b1);
        check("skip_g3", smp_grant, 4'b1000);
        drain(8);

        // Enable gating.
        for (int i = 0; i < 5; i++) begin
            step(4'b0010, 1'b0);
            check("gate_grant", smp_grant, 4'b0000);
            check("gate_valid", smp_valid, 1'b0);
        end
        step(4'b0010, 1'b1);
        check("gate_release", smp_grant, 4'b0010);
        drain(8);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step(4'hF, 1'b1);
        end
        drain(2);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 1'b1);
            check("post_rst_valid", smp_valid, 1'b0);
        end
        step(4'hF, 1'b1);
        check("post_rst_grant", smp_grant, 4'b0001);
        drain(8);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0));
        end
        drain(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
